// File: rtl/dataflow_pkg.sv
// Shared dataflow types and constants.
// Used by req_ack_responder and resp_fifo_mem.
package dataflow_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int COUNT_WIDTH = 32;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } resp_state_e;

  function automatic int ptr_width(input int d);
    return (d < 2) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/resp_fifo_mem.sv
// Register-array storage for the responder FIFO.
// One write port, combinational read at the head.
module resp_fifo_mem
  import dataflow_pkg::*;
#(
  parameter int data_width = DATA_WIDTH_DEFAULT,
  parameter int depth = 4,
  localparam int PW = ptr_width(depth)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PW-1:0]         waddr,
  input  logic [data_width-1:0] wdata,
  input  logic [PW-1:0]         raddr,
  output logic [data_width-1:0] rdata
);

  logic [data_width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/req_ack_responder.sv
// Buffered req/ack responder fed by a valid/ready push port.
// Optional ack counter: REQ_ACK_RESPONDER_COUNT_EN.
module req_ack_responder
  import dataflow_pkg::*;
#(
  parameter int data_width = DATA_WIDTH_DEFAULT,
  parameter int depth = 4,
  localparam int PW = ptr_width(depth),
  localparam int OW = PW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [data_width-1:0]  in_data,
  input  logic                   req,
  output logic                   ack,
  output logic [data_width-1:0]  dout,
`ifdef REQ_ACK_RESPONDER_COUNT_EN
  output logic [COUNT_WIDTH-1:0] count,
`endif
  output logic [OW-1:0]          occupancy
);

  resp_state_e state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [data_width-1:0] head;
  logic push;
  logic pop;

  assign in_ready = (occupancy != OW'(depth));
  assign push = in_valid & in_ready;
  assign pop = req & (state == S_IDLE)
             & (occupancy != '0);
  assign ack = (state == S_ACK);

  resp_fifo_mem #(
    .data_width(data_width),
    .depth(depth)
  ) u_mem (
    .clk(clk),
    .we(push),
    .waddr(wr_ptr),
    .wdata(in_data),
    .raddr(rd_ptr),
    .rdata(head)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      dout <= '0;
      rd_ptr <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            dout <= head;
            rd_ptr <= rd_ptr + 1'b1;
            state <= S_ACK;
          end
        end
        S_ACK: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      unique case ({push, pop})
        2'b10: occupancy <= occupancy + 1'b1;
        2'b01: occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

`ifdef REQ_ACK_RESPONDER_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst) count <= '0;
    else if (pop) count <= count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_req_ack_responder.sv
// Self-checking bench for req_ack_responder (vectors + queue model).
// Compiles with or without REQ_ACK_RESPONDER_COUNT_EN.
module tb_req_ack_responder;

  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [DW-1:0] in_data = '0;
  logic req = 1'b0;
  logic ack;
  logic [DW-1:0] dout;
  logic [2:0] occupancy;
`ifdef REQ_ACK_RESPONDER_COUNT_EN
  logic [31:0] count;
`endif

  int checks = 0;
  int failures = 0;

  // behavioural model
  logic [DW-1:0] mq [$];
  logic m_ack = 1'b0;
  logic [DW-1:0] m_dout = '0;
  logic [31:0] m_count = '0;

  always #5 clk = ~clk;

  req_ack_responder #(
    .data_width(DW),
    .depth(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .req(req),
    .ack(ack),
    .dout(dout),
`ifdef REQ_ACK_RESPONDER_COUNT_EN
    .count(count),
`endif
    .occupancy(occupancy)
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v,
                      input logic [DW-1:0] d, input logic q);
    logic do_push;
    logic do_pop;
    rst = r; in_valid = v; in_data = d; req = q;
    do_push = v && (mq.size() < DEPTH);
    do_pop = q && !m_ack && (mq.size() > 0);
    @(posedge clk);
    #1;
    if (!r) begin
      mq.delete();
      m_ack = 1'b0;
      m_dout = '0;
      m_count = '0;
    end else begin
      m_ack = 1'b0;
      if (do_pop) begin
        m_dout = mq.pop_front();
        m_ack = 1'b1;
        m_count++;
      end
      if (do_push) mq.push_back(d);
    end
    chk("model_ack", 64'(ack), 64'(m_ack));
    chk("model_dout", 64'(dout), 64'(m_dout));
    chk("model_occ", 64'(occupancy), 64'(mq.size()));
    chk("model_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
`ifdef REQ_ACK_RESPONDER_COUNT_EN
    chk("model_count", 64'(count), 64'(m_count));
`endif
  endtask

  typedef struct {
    logic r, v, q;
    logic [DW-1:0] d;
    logic e_ack, e_rdy;
    logic [DW-1:0] e_dout;
    logic [2:0] e_occ;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(logic r, logic v, logic [DW-1:0] d,
                              logic q, logic a, logic [DW-1:0] o,
                              logic [2:0] n, logic y);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.q = q;
    t.e_ack = a; t.e_dout = o; t.e_occ = n; t.e_rdy = y;
    return t;
  endfunction

  initial begin : main
    int sent;
    int got;
    int cyc;
    logic v;
    logic acc;

    // single word
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 'h11, 1, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, 1, 'h11, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 'h11, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 'h11, 0, 1));
    // full FIFO, then drain
    tbl.push_back(mk(1, 1, 0, 0, 0, 'h11, 1, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 'h11, 2, 1));
    tbl.push_back(mk(1, 1, 2, 0, 0, 'h11, 3, 1));
    tbl.push_back(mk(1, 1, 3, 0, 0, 'h11, 4, 0));
    tbl.push_back(mk(1, 1, 4, 0, 0, 'h11, 4, 0));
    tbl.push_back(mk(1, 1, 4, 1, 1, 0, 3, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 3, 1));
    tbl.push_back(mk(1, 0, 0, 1, 1, 1, 2, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 2, 1));
    tbl.push_back(mk(1, 0, 0, 1, 1, 2, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 2, 1, 1));
    // simultaneous push and pop at occupancy 2
    tbl.push_back(mk(1, 1, 4, 0, 0, 2, 2, 1));
    tbl.push_back(mk(1, 1, 5, 1, 1, 3, 2, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 3, 2, 1));
    tbl.push_back(mk(1, 0, 0, 1, 1, 4, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 4, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, 1, 5, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 5, 0, 1));
    // reset with occupancy 3 and ack high
    tbl.push_back(mk(1, 1, 6, 0, 0, 5, 1, 1));
    tbl.push_back(mk(1, 1, 7, 0, 0, 5, 2, 1));
    tbl.push_back(mk(1, 1, 8, 0, 0, 5, 3, 1));
    tbl.push_back(mk(1, 1, 9, 1, 1, 6, 3, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1));

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].q);
      chk($sformatf("v%0d_ack", i), 64'(ack), 64'(tbl[i].e_ack));
      chk($sformatf("v%0d_dout", i), 64'(dout), 64'(tbl[i].e_dout));
      chk($sformatf("v%0d_occ", i), 64'(occupancy), 64'(tbl[i].e_occ));
      chk($sformatf("v%0d_rdy", i), 64'(in_ready), 64'(tbl[i].e_rdy));
    end

    // stream 0..19 with req held high
    step(0, 0, 0, 0);
    sent = 0; got = 0; cyc = 0;
    while (got < 20 && cyc < 200) begin
      v = (sent < 20);
      acc = v && in_ready;
      step(1, v, DW'(sent), 1);
      if (acc) sent++;
      if (ack) begin
        chk("stream_data", 64'(dout), 64'(got));
        got++;
      end
      if (occupancy > 3'd4) chk("stream_occ_max", 64'(occupancy), 64'd4);
      cyc++;
    end
    chk("stream_count", 64'(got), 64'd20);

`ifdef REQ_ACK_RESPONDER_COUNT_EN
    step(0, 0, 0, 0);
    sent = 0; got = 0; cyc = 0;
    while (got < 7 && cyc < 100) begin
      v = (sent < 7);
      acc = v && in_ready;
      step(1, v, DW'(sent + 'h40), 1);
      if (acc) sent++;
      if (ack) got++;
      cyc++;
    end
    chk("count_seven", 64'(count), 64'd7);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 2) != 0,
           $urandom,
           $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/req_ack_responder.md
# req_ack_responder

Buffered responder end of the dataflow req/ack protocol. Words arrive on a push-style valid/ready port. Each word is stored in a small FIFO and served one per request to a downstream initiator (an `async_operator` left port or a `consumer`). The responder returns a single-cycle `ack` with data on `dout`. It replaces the behavioural `producer` when a graph input must be fed from real RTL rather than a testbench model.

## Interface
Parameters:
- `data_width`, 32, width of every data word.
- `depth`, 4, FIFO entries; must be a power of two, minimum 2.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-low (0 = reset).
- `in_valid`  in  1  push side: a word is offered.
- `in_ready`  out  1  push side: FIFO not full.
- `in_data`  in  data_width  push side: data word.
- `req`  in  1  request from the downstream initiator.
- `ack`  out  1  single-cycle response strobe.
- `dout`  out  data_width  response data; valid when `ack`=1 and held until the next ack.
- `occupancy`  out  $clog2(depth)+1  number of stored words.
- `count`  out  32  number of acks issued (present only with the macro, see Configuration).

## Operation
- **Push.** A word is written when `in_valid & in_ready` at a posedge.
  - `in_ready = (occupancy != depth)`; it is combinational from registered state.
  - `in_valid` while full is ignored; the source must hold the word.
- **Response FSM.** Two states, encoded by the `ack` register.
  - IDLE (`ack`=0): at a posedge, if `req & (occupancy != 0)`, the block loads `dout` from the head entry, pops it, sets `ack`=1, and goes to ACK.
  - ACK (`ack`=1): at the next posedge, `ack`=0 and the FSM returns to IDLE unconditionally, even if `req` is still high.
  - Consequence: at most one ack every 2 cycles. This matches the codebase rule `req & ~ack`.
- **Request handling.**
  - `req` with an empty FIFO: no ack; the request stays pending, with no error and no timeout.
  - The initiator may hold `req` high continuously (consumer style) or drop it after ack (`async_operator` style); both are legal.
- **Data path.**
  - `dout` changes only when an ack is issued and is otherwise held.
  - No arithmetic is performed on data.
  - Pointers are `$clog2(depth)` bits and wrap naturally modulo depth.
- **Simultaneous push and pop.** Both take effect in the same cycle:
  - occupancy is unchanged;
  - the FIFO memory is never read and written at the same address in a conflicting way, since push is refused only when full and pop requires non-empty.
- **No bypass.** A word pushed into an empty FIFO at edge N is first ackable at edge N+1.
- **Reset** (`rst`=0 at a posedge), including in the middle of operation:
  - pointers are cleared, `occupancy`=0, stored words are discarded;
  - `ack`=0, `dout`=0, `count`=0;
  - `in_ready` reads 1 once reset is released.

## Timing
- Push-to-ack latency, FIFO empty and `req` already high: 2 edges. Push at edge N, `ack` high after edge N+1.
- Sustained throughput with `req` held high and the FIFO never empty: 1 word per 2 cycles.
  - The push side sees `in_ready` drop once the FIFO fills if `in_valid` is held every cycle.
- `occupancy` is registered: it updates at the edge of the push or pop.
- `ack` is registered and lasts exactly one cycle.

## Configuration
- Macro `REQ_ACK_RESPONDER_COUNT_EN`.
- **Defined:** the `count` port exists.
  - 32-bit register, increments at every edge that sets `ack`, wraps at 2^32, cleared by reset.
  - This is drop-in compatible with the `producer` `count` port for throughput benches.
- **Undefined:** the `count` port and its register are absent; all other behaviour is identical.

## Structure
- Shared package `dataflow_pkg` holds:
  - `DATA_WIDTH_DEFAULT = 32`;
  - `COUNT_WIDTH = 32`;
  - a localparam helper for the pointer width.
- One sub-module, `resp_fifo_mem`: a `depth` x `data_width` register array with one write port and a combinational read port at the head pointer. The FSM and pointer logic live in the top module.

## Test plan
- **Single word.** Reset, push 0x11 at cycle 0, hold `req`=1.
  - Expected: `ack` pulses one cycle at edge 2 with `dout`=0x11.
  - Then `occupancy`=0, and no further ack while `req` stays high.
- **Full FIFO.** With `depth`=4 and `req`=0, push 0..5 with `in_valid` held.
  - Expected: `in_ready`=0 after 4 words and `occupancy`=4.
  - Then assert `req`: acks return 0,1,2,3 in order, one every 2 cycles, and `in_ready` returns to 1 after the first ack.
- **Wrap-around and sustained traffic.** Stream 20 words 0..19 while `req` is held high.
  - Expected: every word is acked exactly once, in order, with no duplicates, and `occupancy` never exceeds 4.
- **Simultaneous push and pop.** With `occupancy`=2, push and issue an ack in the same cycle.
  - Expected: `occupancy` stays 2 and the data order is preserved.
- **Reset mid-operation.** With `occupancy`=3 and `ack`=1, drive `rst`=0 for one edge.
  - Expected: `ack`=0, `dout`=0, `occupancy`=0, `count`=0.
  - After release, `req` alone produces no ack.
- **Count with the macro.** With `REQ_ACK_RESPONDER_COUNT_EN` defined, serve 7 words.
  - Expected: `count`=7.
  - Without the macro, the same bench compiles with the `count` connection removed.
